vga_timing_ctrl: RTL and testbench

Sequencer for the pixel clock generator: starts and stops `pixel_gen`, consumes its `flag_pixel` strobe, and produces horizontal/vertical raster timing for the display output stage. Maintains column/row counters, sync pulses, an active-video qualifier and a frame-start pulse. All state advances only on `flag_pixel`, so raster timing tracks the pixel rate rather than the system clock.

---
 rtl/vga_timing_ctrl.sv | 168 ++++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// vga_timing_ctrl
//
// This module sequences the pixel clock generator and produces raster timing.
// It starts and stops pixel_gen through pixel_enable. It advances the column
// and row counters once per flag_pixel strobe. It decodes hsync, vsync and
// active_video, and it pulses frame_start at the start of each frame.
//
// Ports
//   clk          : system clock, rising edge
//   n_rst        : synchronous, active-low reset
//   enable       : run request (level)
//   flag_pixel   : one-cycle pixel strobe from pixel_gen
//   pixel_enable : enable for pixel_gen
//   hsync        : horizontal sync, active-low
//   vsync        : vertical sync, active-low
//   active_video : current (x,y) lies in the visible area
//   x, y         : current column / row
//   frame_start  : one-cycle pulse at the start of each frame
// ---------------------------------------------------------------------------
module vga_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             enable,
    input  logic             flag_pixel,
    output logic             pixel_enable,
    output logic             hsync,
    output logic             vsync,
    output logic             active_video,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_END = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS_END = CNT_W'(V_ACTIVE);
    // The sync windows are half-open: [start, end).
    localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] hcount_reg, hcount_next;
    logic [CNT_W-1:0] vcount_reg, vcount_next;
    logic             hsync_reg, hsync_next;
    logic             vsync_reg, vsync_next;
    logic             active_reg, active_next;
    logic             frame_start_reg, frame_start_next;
    logic             pixel_enable_reg, pixel_enable_next;

    logic advance;
    logic at_wrap;

    assign advance = (state_reg != ST_IDLE) && flag_pixel;
    assign at_wrap = (hcount_reg == H_LAST) && (vcount_reg == V_LAST);

    always_comb begin
        state_next        = state_reg;
        hcount_next       = hcount_reg;
        vcount_next       = vcount_reg;
        frame_start_next  = 1'b0;
        hsync_next        = 1'b1;
        vsync_next        = 1'b1;
        active_next       = 1'b0;
        pixel_enable_next = 1'b0;

        if (advance) begin
            if (hcount_reg == H_LAST) begin
                hcount_next = '0;
                vcount_next = (vcount_reg == V_LAST) ? '0 : vcount_reg + 1'b1;
            end else begin
                hcount_next = hcount_reg + 1'b1;
            end
        end

        unique case (state_reg)
            ST_IDLE: begin
                if (enable) begin
                    state_next       = ST_RUN;
                    frame_start_next = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // If enable is raised again, the raster keeps running without
                // a gap. This takes priority over the drain completing.
                if (enable) begin
                    state_next = ST_RUN;
                end else if (advance && at_wrap) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (advance && at_wrap && (state_next != ST_IDLE)) begin
            frame_start_next = 1'b1;
        end

        if (state_next == ST_IDLE) begin
            hcount_next = '0;
            vcount_next = '0;
        end else begin
            // Decode from the next counts so the syncs line up with x/y.
            pixel_enable_next = 1'b1;
            hsync_next  = !((hcount_next >= H_SYNC_START) && (hcount_next < H_SYNC_END));
            vsync_next  = !((vcount_next >= V_SYNC_START) && (vcount_next < V_SYNC_END));
            active_next = (hcount_next < H_VIS_END) && (vcount_next < V_VIS_END);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg        <= ST_IDLE;
            hcount_reg       <= '0;
            vcount_reg       <= '0;
            hsync_reg        <= 1'b1;
            vsync_reg        <= 1'b1;
            active_reg       <= 1'b0;
            frame_start_reg  <= 1'b0;
            pixel_enable_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            hcount_reg       <= hcount_next;
            vcount_reg       <= vcount_next;
            hsync_reg        <= hsync_next;
            vsync_reg        <= vsync_next;
            active_reg       <= active_next;
            frame_start_reg  <= frame_start_next;
            pixel_enable_reg <= pixel_enable_next;
        end
    end

    assign pixel_enable = pixel_enable_reg;
    assign hsync        = hsync_reg;
    assign vsync        = vsync_reg;
    assign active_video = active_reg;
    assign x            = hcount_reg;
    assign y            = vcount_reg;
    assign frame_start  = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_ctrl
//
// This bench checks vga_timing_ctrl against a behavioural raster model.
// It uses a reduced raster so that several full frames fit in a short run.
// Every cycle it compares each DUT output with the model.
// ---------------------------------------------------------------------------
module tb_vga_timing_ctrl;

    localparam int HA = 16, HF = 4, HS = 6, HB = 6;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int CW = 6;
    localparam int HT = HA + HF + HS + HB;   // 32
    localparam int VT = VA + VF + VS + VB;   // 19

    logic          clk;
    logic          n_rst;
    logic          enable;
    logic          flag_pixel;
    logic          pixel_enable;
    logic          hsync;
    logic          vsync;
    logic          active_video;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          frame_start;

    int errors = 0;
    int checks = 0;

    // Model state: mode 0 = stopped, 1 = running, 2 = finishing the frame.
    int mmode = 0;
    int mx    = 0;
    int my    = 0;
    bit mfs   = 0;

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .enable(enable),
        .flag_pixel(flag_pixel),
        .pixel_enable(pixel_enable),
        .hsync(hsync),
        .vsync(vsync),
        .active_video(active_video),
        .x(x),
        .y(y),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (model x=%0d y=%0d mode=%0d)",
                   tag, obs, exp, mx, my, mmode);
        end
    endtask

    // Advance the model by one clock edge, using the inputs seen at that edge.
    task automatic model_update(input logic r, input logic e, input logic f);
        bit wrap;
        int prev;
        if (!r) begin
            mmode = 0; mx = 0; my = 0; mfs = 0;
        end else if (mmode == 0) begin
            mfs = e;
            if (e) mmode = 1;
        end else begin
            prev = mmode;
            wrap = f && (mx == HT - 1) && (my == VT - 1);
            if (f) begin
                mx = (mx + 1) % HT;
                if (mx == 0) my = (my + 1) % VT;
            end
            if (prev == 1 && !e) mmode = 2;
            else if (prev == 2 && e) mmode = 1;
            else if (prev == 2 && wrap) mmode = 0;
            mfs = wrap && (mmode != 0);
        end
    endtask

    task automatic compare_all();
        bit run;
        run = (mmode != 0);
        check("pixel_enable", 32'(pixel_enable), 32'(run));
        check("x", 32'(x), 32'(mx));
        check("y", 32'(y), 32'(my));
        check("hsync", 32'(hsync), run ? 32'(!(mx >= HA + HF && mx < HA + HF + HS)) : 32'd1);
        check("vsync", 32'(vsync), run ? 32'(!(my >= VA + VF && my < VA + VF + VS)) : 32'd1);
        check("active_video", 32'(active_video), 32'(run && mx < HA && my < VA));
        check("frame_start", 32'(frame_start), 32'(mfs));
    endtask

    task automatic step(input logic r, input logic e, input logic f);
        n_rst = r; enable = e; flag_pixel = f;
        @(posedge clk);
        model_update(r, e, f);
        #1;
        compare_all();
    endtask

    function automatic logic rnd_flag();
        return ($urandom_range(0, 2) != 0);
    endfunction

    initial begin
        int guard;
        int fs_count;
        n_rst = 1'b0; enable = 1'b1; flag_pixel = 1'b0;

        // Reset held for three clocks while enable is high and the strobe toggles.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'(i % 2));

        // In idle, strobes are ignored.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);

        // Start with a strobe in the same cycle. The strobe is ignored.
        step(1'b1, 1'b1, 1'b1);
        check("start_frame_pulse", 32'(frame_start), 32'd1);
        step(1'b1, 1'b1, 1'b0);
        check("start_pulse_single", 32'(frame_start), 32'd0);

        // Strobe every 2 clocks, then leave gaps of 5 clocks.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b1);
            step(1'b1, 1'b1, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b1);
            for (int j = 0; j < 5; j++) step(1'b1, 1'b1, 1'b0);
        end

        // Random strobes across more than two full frames.
        fs_count = 0;
        for (int i = 0; i < 2000; i++) begin
            step(1'b1, 1'b1, rnd_flag());
            if (frame_start) fs_count++;
        end
        check("frames_seen_nonzero", 32'(fs_count > 0), 32'd1);

        // Run to (HT-1, VT-1), then one strobe wraps to (0,0) with a pulse.
        guard = 0;
        while (!(mx == HT - 1 && my == VT - 1) && guard < 2000) begin
            step(1'b1, 1'b1, 1'b1); guard++;
        end
        step(1'b1, 1'b1, 1'b1);
        check("wrap_x", 32'(x), 32'd0);
        check("wrap_y", 32'(y), 32'd0);
        check("wrap_frame_start", 32'(frame_start), 32'd1);

        // Drop enable at (10,8). The frame then completes and the design stops.
        guard = 0;
        while (!(mx == 10 && my == 8) && guard < 2000) begin
            step(1'b1, 1'b1, 1'b1); guard++;
        end
        guard = 0;
        step(1'b1, 1'b0, 1'b0);
        check("drain_pe_held", 32'(pixel_enable), 32'd1);
        while (mmode != 0 && guard < 5000) begin
            step(1'b1, 1'b0, rnd_flag()); guard++;
        end
        check("drain_done_pe", 32'(pixel_enable), 32'd0);
        check("drain_done_x", 32'(x), 32'd0);
        check("drain_done_y", 32'(y), 32'd0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1);

        // Restart. Drop enable briefly, then raise it again during the drain.
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, rnd_flag());
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, rnd_flag());
        for (int i = 0; i < 900; i++) step(1'b1, 1'b1, rnd_flag());

        // Random enable toggling with random strobes.
        for (int i = 0; i < 1500; i++) begin
            step(1'b1, ($urandom_range(0, 15) != 0), rnd_flag());
        end

        // Reset in mid-frame at (20,5), then re-enable from (0,0).
        step(1'b1, 1'b1, 1'b0);
        guard = 0;
        while (!(mx == 20 && my == 5) && guard < 2000) begin
            step(1'b1, 1'b1, 1'b1); guard++;
        end
        step(1'b0, 1'b1, 1'b1);
        check("midreset_x", 32'(x), 32'd0);
        check("midreset_pe", 32'(pixel_enable), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        check("restart_pulse", 32'(frame_start), 32'd1);
        for (int i = 0; i < 50; i++) step(1'b1, 1'b1, rnd_flag());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
